// File: rtl/riscv_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_muldiv_unit
//  Purpose  : Iterative RV32M/RV64M multiply/divide unit for the execute stage.
//             One operation per accepted start, computed bit-serially:
//             XLEN CALC cycles, one FIX (sign correction) cycle, one DONE
//             cycle. Special cases (divide by zero, signed overflow) follow
//             the same path, so latency never varies.
//  Ports    : clk     - rising-edge clock
//             reset   - synchronous active-high reset
//             start   - operation request, honoured only while idle
//             flush   - synchronous abort, wins over start
//             funct3  - M-extension op (MUL..REMU)
//             src_a   - rs1 operand, captured with start
//             src_b   - rs2 operand, captured with start
//             busy    - operation in flight (CALC or FIX)
//             done    - one-cycle pulse, result valid
//             result  - last completed result, held between operations
//  Revision : 1.0 - initial release
// ============================================================================
module riscv_muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int c_CNT_W = $clog2(XLEN);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_CALC = 2'd1;
    localparam logic [1:0] c_ST_FIX  = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    localparam logic [2:0] c_OP_MUL    = 3'd0;
    localparam logic [2:0] c_OP_MULH   = 3'd1;
    localparam logic [2:0] c_OP_MULHSU = 3'd2;
    localparam logic [2:0] c_OP_MULHU  = 3'd3;
    localparam logic [2:0] c_OP_DIV    = 3'd4;
    localparam logic [2:0] c_OP_DIVU   = 3'd5;
    localparam logic [2:0] c_OP_REM    = 3'd6;
    localparam logic [2:0] c_OP_REMU   = 3'd7;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [c_CNT_W-1:0] r_count;
    // Multiply: {carry, product_hi, multiplier/product_lo}
    // Divide  : {partial remainder (XLEN+1 bits), dividend/quotient}
    logic [2*XLEN:0]    r_acc;
    // Multiplicand magnitude for multiply, divisor magnitude for divide
    logic [XLEN-1:0]    r_operand;
    logic [2:0]         r_funct3;
    logic               r_neg_res;   // negate product / quotient in FIX
    logic               r_neg_rem;   // negate remainder in FIX
    logic [XLEN-1:0]    r_result;

    // ------------------------------------------------------------------------
    // Operand conditioning at capture time
    // ------------------------------------------------------------------------
    logic            w_accept;
    logic            w_a_signed;
    logic            w_b_signed;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic            w_in_is_div;
    logic            w_in_neg_res;

    assign w_accept    = (r_state == c_ST_IDLE) && start && !flush;
    assign w_in_is_div = funct3[2];

    // MULHSU treats only rs1 as signed; MULHU/DIVU/REMU and MUL are unsigned
    // (MUL's low half is sign-agnostic).
    assign w_a_signed = (funct3 == c_OP_MULH) || (funct3 == c_OP_MULHSU) ||
                        (funct3 == c_OP_DIV)  || (funct3 == c_OP_REM);
    assign w_b_signed = (funct3 == c_OP_MULH) || (funct3 == c_OP_DIV) ||
                        (funct3 == c_OP_REM);

    assign w_a_neg = w_a_signed && src_a[XLEN-1];
    assign w_b_neg = w_b_signed && src_b[XLEN-1];
    assign w_a_mag = w_a_neg ? -src_a : src_a;
    assign w_b_mag = w_b_neg ? -src_b : src_b;

    // Dividing by zero yields an all-ones magnitude quotient; keeping it
    // un-negated gives the required all-ones result for signed DIV too.
    assign w_in_neg_res = w_in_is_div ? ((w_a_neg ^ w_b_neg) && (src_b != '0))
                                      : (w_a_neg ^ w_b_neg);

    // ------------------------------------------------------------------------
    // Multiply iteration: conditional add into the upper half, then shift
    // the whole accumulator right so the next multiplier bit lands in bit 0.
    // ------------------------------------------------------------------------
    logic [XLEN-1:0] w_addend;
    logic [XLEN:0]   w_sum;
    logic [2*XLEN:0] w_mul_next;

    assign w_addend   = r_acc[0] ? r_operand : '0;
    assign w_sum      = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, w_addend};
    assign w_mul_next = {1'b0, w_sum, r_acc[XLEN-1:1]};

    // ------------------------------------------------------------------------
    // Restoring divide iteration: shift the next dividend bit into the
    // partial remainder, trial-subtract the divisor, keep it if non-negative.
    // ------------------------------------------------------------------------
    logic [XLEN+1:0] w_rem_shift;
    logic [XLEN+1:0] w_diff;
    logic            w_q_bit;
    logic [2*XLEN:0] w_div_next;

    assign w_rem_shift = {r_acc[2*XLEN:XLEN], r_acc[XLEN-1]};
    assign w_diff      = w_rem_shift - {2'b00, r_operand};
    assign w_q_bit     = !w_diff[XLEN+1];
    assign w_div_next  = {(w_q_bit ? w_diff[XLEN:0] : w_rem_shift[XLEN:0]),
                          r_acc[XLEN-2:0], w_q_bit};

    // ------------------------------------------------------------------------
    // Sign correction and op select
    // ------------------------------------------------------------------------
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_quot_fix;
    logic [XLEN-1:0]   w_rem_fix;
    logic [XLEN-1:0]   w_fix_result;

    assign w_prod_fix = r_neg_res ? -r_acc[2*XLEN-1:0] : r_acc[2*XLEN-1:0];
    assign w_quot_fix = r_neg_res ? -r_acc[XLEN-1:0]   : r_acc[XLEN-1:0];
    assign w_rem_fix  = r_neg_rem ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

    always_comb begin
        w_fix_result = '0;
        case (r_funct3)
            c_OP_MUL:                           w_fix_result = w_prod_fix[XLEN-1:0];
            c_OP_MULH, c_OP_MULHSU, c_OP_MULHU: w_fix_result = w_prod_fix[2*XLEN-1:XLEN];
            c_OP_DIV, c_OP_DIVU:                w_fix_result = w_quot_fix;
            c_OP_REM, c_OP_REMU:                w_fix_result = w_rem_fix;
            default:                            w_fix_result = '0;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = c_ST_CALC;
                end
            end
            c_ST_CALC: begin
                if (flush) begin
                    w_next_state = c_ST_IDLE;
                end else if (r_count == '0) begin
                    w_next_state = c_ST_FIX;
                end
            end
            c_ST_FIX: begin
                w_next_state = flush ? c_ST_IDLE : c_ST_DONE;
            end
            c_ST_DONE: begin
                w_next_state = c_ST_IDLE;
            end
            default: begin
                w_next_state = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs, decoded from registered state only
    // ------------------------------------------------------------------------
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            c_ST_CALC: busy = 1'b1;
            c_ST_FIX:  busy = 1'b1;
            c_ST_DONE: done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    assign result = r_result;

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count   <= '0;
            r_acc     <= '0;
            r_operand <= '0;
            r_funct3  <= '0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_result  <= '0;
        end else begin
            if (w_accept) begin
                r_funct3  <= funct3;
                r_count   <= c_CNT_W'(XLEN - 1);
                r_neg_res <= w_in_neg_res;
                r_neg_rem <= w_a_neg;
                // Divide iterates over the dividend; multiply over the multiplier.
                r_acc     <= w_in_is_div ? {{(XLEN+1){1'b0}}, w_a_mag}
                                         : {{(XLEN+1){1'b0}}, w_b_mag};
                r_operand <= w_in_is_div ? w_b_mag : w_a_mag;
            end else if ((r_state == c_ST_CALC) && !flush) begin
                r_acc   <= r_funct3[2] ? w_div_next : w_mul_next;
                r_count <= r_count - c_CNT_W'(1);
            end else if ((r_state == c_ST_FIX) && !flush) begin
                r_result <= w_fix_result;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_riscv_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_riscv_muldiv_unit
//  Purpose  : Self-checking bench for riscv_muldiv_unit (XLEN=32): directed
//             corner cases, flush/reset aborts, back-to-back starts and
//             randomized operations against an arithmetic reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_muldiv_unit;

    localparam int c_XLEN    = 32;
    localparam int c_LATENCY = c_XLEN + 2;
    localparam int c_SPACING = c_XLEN + 3;

    logic              clk;
    logic              reset;
    logic              start;
    logic              flush;
    logic [2:0]        funct3;
    logic [c_XLEN-1:0] src_a;
    logic [c_XLEN-1:0] src_b;
    logic              busy;
    logic              done;
    logic [c_XLEN-1:0] result;

    int n_checks;
    int n_fail;

    riscv_muldiv_unit #(.XLEN(c_XLEN)) u_dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .flush  (flush),
        .funct3 (funct3),
        .src_a  (src_a),
        .src_b  (src_b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: plain 64-bit arithmetic from the RISC-V M rules.
    function automatic logic [31:0] model(input logic [2:0] f,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ua;
        longint      ub;
        logic [63:0] p;
        logic [63:0] ua64;
        logic [63:0] ub64;
        sa   = longint'(signed'(a));
        sb   = longint'(signed'(b));
        ua   = longint'({32'd0, a});
        ub   = longint'({32'd0, b});
        ua64 = {32'd0, a};
        ub64 = {32'd0, b};
        p    = '0;
        case (f)
            3'd0: begin p = ua64 * ub64; return p[31:0];  end
            3'd1: begin p = sa * sb;     return p[63:32]; end
            3'd2: begin p = sa * ub;     return p[63:32]; end
            3'd3: begin p = ua64 * ub64; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom % 6)
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom % 16);
            default: return 32'($urandom);
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one op and follow it to completion. With noisy set, start and
    // operands toggle randomly while the unit is busy and must be ignored.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input bit noisy, input string tag);
        logic [31:0] exp;
        int          lat;
        bit          busy_ok;
        bit          seen;
        exp    = model(f, a, b);
        funct3 = f;
        src_a  = a;
        src_b  = b;
        start  = 1'b1;
        @(posedge clk); #1;
        lat     = 1;
        seen    = 1'b0;
        busy_ok = 1'b1;
        start   = 1'b0;
        while (lat < 100) begin
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
            funct3 = 3'($urandom);
            src_a  = 32'($urandom);
            src_b  = 32'($urandom);
            start  = noisy ? 1'($urandom) : 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        check({tag, " done_seen"}, 64'(seen), 64'd1);
        check({tag, " latency"}, 64'(lat), 64'(c_LATENCY));
        check({tag, " result"}, 64'(result), 64'(exp));
        check({tag, " busy_in_flight"}, 64'(busy_ok), 64'd1);
        check({tag, " busy_at_done"}, 64'(busy), 64'd0);
        @(posedge clk); #1;
        check({tag, " done_single"}, 64'(done), 64'd0);
        check({tag, " idle_after"}, 64'(busy), 64'd0);
    endtask

    // Count done pulses over a window; none are expected after an abort.
    task automatic expect_no_done(input string tag, input int cycles);
        int pulses;
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) pulses++;
        end
        check({tag, " no_done"}, 64'(pulses), 64'd0);
    endtask

    initial begin
        logic [2:0]  bf;
        logic [31:0] ba;
        logic [31:0] bb;
        logic [31:0] bexp;
        int          since;
        int          pulses;
        int          guard;

        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        flush    = 1'b0;
        start    = 1'b1;
        funct3   = 3'($urandom);
        src_a    = 32'($urandom);
        src_b    = 32'($urandom);

        // Reset with random inputs and start asserted
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("reset busy", 64'(busy), 64'd0);
            check("reset done", 64'(done), 64'd0);
            check("reset result", 64'(result), 64'd0);
            funct3 = 3'($urandom);
            src_a  = 32'($urandom);
            src_b  = 32'($urandom);
        end
        reset = 1'b0;
        start = 1'b0;
        @(posedge clk); #1;
        check("post_reset busy", 64'(busy), 64'd0);
        check("post_reset done", 64'(done), 64'd0);

        // Multiply set on all-ones operands
        run_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "MUL_ff");
        check("MUL_ff const", 64'(result), 64'h0000_0001);
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "MULH_ff");
        check("MULH_ff const", 64'(result), 64'h0000_0000);
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "MULHSU_ff");
        check("MULHSU_ff const", 64'(result), 64'hFFFF_FFFF);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "MULHU_ff");
        check("MULHU_ff const", 64'(result), 64'hFFFF_FFFE);

        // Divide signs, -7 / 2
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0, "DIV_m7");
        check("DIV_m7 const", 64'(result), 64'hFFFF_FFFD);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 1'b0, "REM_m7");
        check("REM_m7 const", 64'(result), 64'hFFFF_FFFF);
        run_op(3'd5, 32'hFFFF_FFF9, 32'd2, 1'b1, "DIVU_m7");
        check("DIVU_m7 const", 64'(result), 64'h7FFF_FFFC);
        run_op(3'd7, 32'hFFFF_FFF9, 32'd2, 1'b0, "REMU_m7");
        check("REMU_m7 const", 64'(result), 64'h0000_0001);

        // Divide by zero and signed overflow
        run_op(3'd4, 32'd5, 32'd0, 1'b0, "DIV_by0");
        check("DIV_by0 const", 64'(result), 64'hFFFF_FFFF);
        run_op(3'd5, 32'd5, 32'd0, 1'b0, "DIVU_by0");
        run_op(3'd6, 32'd5, 32'd0, 1'b0, "REM_by0");
        check("REM_by0 const", 64'(result), 64'd5);
        run_op(3'd7, 32'd5, 32'd0, 1'b0, "REMU_by0");
        run_op(3'd4, 32'hFFFF_FFF9, 32'd0, 1'b0, "DIV_neg_by0");
        run_op(3'd6, 32'hFFFF_FFF9, 32'd0, 1'b0, "REM_neg_by0");
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "DIV_ovf");
        check("DIV_ovf const", 64'(result), 64'h8000_0000);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "REM_ovf");
        check("REM_ovf const", 64'(result), 64'd0);

        // Flush mid-operation
        run_op(3'd0, 32'd3, 32'd4, 1'b0, "MUL_3x4");
        check("MUL_3x4 const", 64'(result), 64'd12);
        funct3 = 3'd0; src_a = 32'd6; src_b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush busy", 64'(busy), 64'd0);
        check("flush done", 64'(done), 64'd0);
        check("flush result", 64'(result), 64'd12);
        expect_no_done("flush", 40);
        check("flush result_held", 64'(result), 64'd12);
        run_op(3'd5, 32'd100, 32'd7, 1'b0, "DIVU_100_7");
        check("DIVU_100_7 const", 64'(result), 64'd14);

        // Reset mid-operation
        funct3 = 3'd0; src_a = 32'd6; src_b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midreset busy", 64'(busy), 64'd0);
        check("midreset result", 64'(result), 64'd0);
        expect_no_done("midreset", 40);

        // Flush and start together in IDLE: nothing is accepted
        funct3 = 3'd0; src_a = 32'd9; src_b = 32'd9; start = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        check("flush_start busy", 64'(busy), 64'd0);
        expect_no_done("flush_start", 40);
        check("flush_start result", 64'(result), 64'd0);

        // Back-to-back: start held high, operands change every cycle
        bf = 3'($urandom); ba = pick_operand(); bb = pick_operand();
        funct3 = bf; src_a = ba; src_b = bb; start = 1'b1;
        bexp   = model(bf, ba, bb);
        since  = 0;
        pulses = 0;
        guard  = 0;
        while (pulses < 4 && guard < 400) begin
            @(posedge clk); #1;
            since++;
            guard++;
            if (done === 1'b1) begin
                pulses++;
                check("b2b result", 64'(result), 64'(bexp));
                check("b2b spacing", 64'(since), (pulses == 1) ? 64'(c_LATENCY) : 64'(c_SPACING));
                check("b2b busy_at_done", 64'(busy), 64'd0);
                if (pulses == 4) begin
                    start = 1'b0;
                end else begin
                    // Operands in the done cycle must be ignored
                    funct3 = 3'($urandom); src_a = 32'($urandom); src_b = 32'($urandom);
                    @(posedge clk); #1;
                    since = 1;
                    check("b2b idle_gap", 64'(busy), 64'd0);
                    bf = 3'($urandom); ba = pick_operand(); bb = pick_operand();
                    funct3 = bf; src_a = ba; src_b = bb;
                    bexp = model(bf, ba, bb);
                end
            end else begin
                funct3 = 3'($urandom); src_a = 32'($urandom); src_b = 32'($urandom);
            end
        end
        start = 1'b0;
        check("b2b pulse_count", 64'(pulses), 64'd4);
        @(posedge clk); #1;
        check("b2b drained", 64'(busy), 64'd0);

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            run_op(3'($urandom), pick_operand(), pick_operand(), 1'($urandom), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
